cordic_rr_sched: RTL and testbench

- Round-robin scheduler that shares one fully pipelined CORDIC rotation core between NREQ requesters.
- Accepts at most one (x0,y0,z0) job per cycle and registers the winner onto the core inputs.
- Tracks each in-flight job's requester id in a valid/tag shift pipe matched to the core latency, then returns results tagged with that id.
- Provides a drain/halt handshake so software can quiesce the core before reconfiguring it.

---
 rtl/cordic_pkg.sv | 22 ++
 rtl/cordic_rr_sched_if.sv | 48 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/cordic_rr_sched.sv | 177 +++++++++++++++++
 tb/tb_cordic_rr_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC round-robin scheduler slice.
package cordic_pkg;

  localparam int unsigned CORDIC_DATA_W  = 32;
  localparam int unsigned CORDIC_LATENCY = 17;
  localparam int unsigned CORDIC_STAGES  = 16;

  // atan(2^-i) with one full turn scaled to 2^32
  localparam logic [31:0] CORDIC_ATAN [CORDIC_STAGES] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sched_state_t;

endpackage

// File: rtl/cordic_rr_sched_if.sv
// Requester, core-side and drain-control bundle for cordic_rr_sched.
// stat_clr/stat_grants exist only when CORDIC_RR_SCHED_STATS_EN is defined.
interface cordic_rr_sched_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_x0;
  logic [NREQ*DATA_W-1:0] req_y0;
  logic [NREQ*DATA_W-1:0] req_z0;
  logic [DATA_W-1:0]      core_x0;
  logic [DATA_W-1:0]      core_y0;
  logic [DATA_W-1:0]      core_z0;
  logic [DATA_W-1:0]      core_x;
  logic [DATA_W-1:0]      core_y;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [DATA_W-1:0]      rsp_x;
  logic [DATA_W-1:0]      rsp_y;
  logic                   drain_req;
  logic                   drain_done;
  logic                   busy;
`ifdef CORDIC_RR_SCHED_STATS_EN
  logic                   stat_clr;
  logic [NREQ*16-1:0]     stat_grants;
`endif

  modport master (
    output req_valid, req_x0, req_y0, req_z0, core_x, core_y, drain_req,
    input  req_ready, core_x0, core_y0, core_z0, rsp_valid, rsp_id,
    input  rsp_x, rsp_y, drain_done, busy
`ifdef CORDIC_RR_SCHED_STATS_EN
    , output stat_clr, input stat_grants
`endif
  );

  modport slave (
    input  req_valid, req_x0, req_y0, req_z0, core_x, core_y, drain_req,
    output req_ready, core_x0, core_y0, core_z0, rsp_valid, rsp_id,
    output rsp_x, rsp_y, drain_done, busy
`ifdef CORDIC_RR_SCHED_STATS_EN
    , input stat_clr, output stat_grants
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotate-priority arbiter: search starts one past i_ptr, one-hot grant plus id.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);

  always_comb begin
    logic [ID_W-1:0] w_idx;
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    if (i_en) begin
      for (int unsigned off = 1; off <= NREQ; off++) begin
        w_idx = ID_W'((32'(i_ptr) + off) % NREQ);
        if (!o_any && i_req[w_idx]) begin
          o_grant[w_idx] = 1'b1;
          o_id           = w_idx;
          o_any          = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// Round-robin front end sharing one pipelined CORDIC core among NREQ requesters.
// Optional per-requester grant counters: define CORDIC_RR_SCHED_STATS_EN.
module cordic_rr_sched
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DATA_W  = CORDIC_DATA_W,
  parameter int unsigned LATENCY = CORDIC_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  cordic_rr_sched_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] INFL_MAX = CNT_W'(LATENCY + 1);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic              w_arb_en;
  logic              w_drain_done;
  logic [NREQ-1:0]   w_gnt;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_gnt_any;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] w_sel_x;
  logic [DATA_W-1:0] w_sel_y;
  logic [DATA_W-1:0] w_sel_z;
  logic [DATA_W-1:0] r_core_x0;
  logic [DATA_W-1:0] r_core_y0;
  logic [DATA_W-1:0] r_core_z0;
  logic              r_issue_v;
  logic [ID_W-1:0]   r_issue_id;
  logic [LATENCY-1:0] r_vpipe;
  logic [ID_W-1:0]   r_tpipe [LATENCY];
  logic [CNT_W-1:0]  r_inflight;
  logic              w_rsp_v;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_en    (w_arb_en),
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_gnt),
    .o_id    (w_gnt_id),
    .o_any   (w_gnt_any)
  );

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    w_sel_z = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_x = bus.req_x0[i*DATA_W +: DATA_W];
        w_sel_y = bus.req_y0[i*DATA_W +: DATA_W];
        w_sel_z = bus.req_z0[i*DATA_W +: DATA_W];
      end
    end
  end

  // Operands hold their last value when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= ID_W'(NREQ - 1);
      r_core_x0  <= '0;
      r_core_y0  <= '0;
      r_core_z0  <= '0;
      r_issue_v  <= 1'b0;
      r_issue_id <= '0;
    end else begin
      r_issue_v  <= w_gnt_any;
      r_issue_id <= w_gnt_id;
      if (w_gnt_any) begin
        r_rr_ptr  <= w_gnt_id;
        r_core_x0 <= w_sel_x;
        r_core_y0 <= w_sel_y;
        r_core_z0 <= w_sel_z;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpipe <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_tpipe[i] <= '0;
    end else begin
      r_vpipe    <= {r_vpipe[LATENCY-2:0], r_issue_v};
      r_tpipe[0] <= r_issue_id;
      for (int unsigned i = 1; i < LATENCY; i++) r_tpipe[i] <= r_tpipe[i-1];
    end
  end

  assign w_rsp_v = r_vpipe[LATENCY-1];

  // Counts issue register plus tag pipe occupancy, so it peaks at LATENCY+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_gnt_any, w_rsp_v})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (bus.drain_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!bus.drain_req)          w_state_nxt = RUN;
        else if (r_inflight == '0)   w_state_nxt = HALTED;
      end
      HALTED: begin
        if (!bus.drain_req) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_arb_en     = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      RUN:     w_arb_en     = 1'b1;
      HALTED:  w_drain_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready  = w_gnt;
  assign bus.core_x0    = r_core_x0;
  assign bus.core_y0    = r_core_y0;
  assign bus.core_z0    = r_core_z0;
  assign bus.rsp_valid  = w_rsp_v;
  assign bus.rsp_id     = r_tpipe[LATENCY-1];
  assign bus.rsp_x      = bus.core_x;
  assign bus.rsp_y      = bus.core_y;
  assign bus.drain_done = w_drain_done;
  assign bus.busy       = (r_inflight != '0);

`ifdef CORDIC_RR_SCHED_STATS_EN
  logic [15:0] r_stat [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) r_stat[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (bus.stat_clr)                        r_stat[i] <= '0;
        else if (w_gnt[i] && (r_stat[i] != '1)) r_stat[i] <= r_stat[i] + 16'd1;
      end
    end
  end

  always_comb begin
    bus.stat_grants = '0;
    for (int unsigned i = 0; i < NREQ; i++) bus.stat_grants[i*16 +: 16] = r_stat[i];
  end
`endif

  a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n) r_inflight <= INFL_MAX);

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Directed bench for cordic_rr_sched with a behavioural 17-stage CORDIC core and response scoreboard.
module tb_cordic_rr_sched;
  import cordic_pkg::*;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int DW   = 32;
  localparam int LAT  = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_rr_sched_if #(.NREQ(NREQ), .ID_W(ID_W), .DATA_W(DW)) bus ();

  cordic_rr_sched #(
    .NREQ    (NREQ),
    .ID_W    (ID_W),
    .DATA_W  (DW),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [63:0] cordic_ref(input logic [31:0] x0, input logic [31:0] y0,
                                             input logic [31:0] z0);
    logic signed [31:0] x, y, z, xt;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < 16; i++) begin
      xt = x;
      if (!z[31]) begin
        x = x - (y >>> i); y = y + (xt >>> i); z = z - CORDIC_ATAN[i];
      end else begin
        x = x + (y >>> i); y = y - (xt >>> i); z = z + CORDIC_ATAN[i];
      end
    end
    return {x, y};
  endfunction

  // behavioural core: 16 stage registers plus output register
  logic [31:0] cpx [LAT];
  logic [31:0] cpy [LAT];
  always @(posedge clk) begin
    {cpx[0], cpy[0]} <= cordic_ref(bus.core_x0, bus.core_y0, bus.core_z0);
    for (int i = 1; i < LAT; i++) begin
      cpx[i] <= cpx[i-1];
      cpy[i] <= cpy[i-1];
    end
  end
  assign bus.core_x = cpx[LAT-1];
  assign bus.core_y = cpy[LAT-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int unsigned     due;
    logic [ID_W-1:0] id;
    logic [31:0]     x;
    logic [31:0]     y;
  } exp_t;

  typedef struct {
    int unsigned     at;
    logic [ID_W-1:0] id;
    logic [31:0]     x;
    logic [31:0]     y;
  } rlog_t;

  exp_t  sb[$];
  exp_t  sb_head;
  rlog_t rlog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_head.due = cyc + 18;
          sb_head.id  = ID_W'(i);
          {sb_head.x, sb_head.y} = cordic_ref(bus.req_x0[i*DW +: DW], bus.req_y0[i*DW +: DW],
                                              bus.req_z0[i*DW +: DW]);
          sb.push_back(sb_head);
        end
      end
      if (bus.rsp_valid) begin
        rlog.push_back('{cyc, bus.rsp_id, bus.rsp_x, bus.rsp_y});
        if (sb.size() == 0) begin
          check("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
        end else begin
          sb_head = sb.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(sb_head.due));
          check("rsp_id", 64'(bus.rsp_id), 64'(sb_head.id));
          check("rsp_x", 64'(bus.rsp_x), 64'(sb_head.x));
          check("rsp_y", 64'(bus.rsp_y), 64'(sb_head.y));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("rsp_missing", 64'(bus.rsp_valid), 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [31:0] dx(input int k, input int i);
    return 32'((k * 64 + i * 8 + 1) << 12);
  endfunction
  function automatic logic [31:0] dy(input int k, input int i);
    return 32'((i * 4 + k + 3) << 10);
  endfunction
  function automatic logic [31:0] dz(input int k, input int i);
    return 32'(k * 32'h0089_0000 + i * 32'h0110_0000);
  endfunction

  task automatic set_data(input int k);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x0[i*DW +: DW] = dx(k, i);
      bus.req_y0[i*DW +: DW] = dy(k, i);
      bus.req_z0[i*DW +: DW] = dz(k, i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.drain_req = 1'b0;
`ifdef CORDIC_RR_SCHED_STATS_EN
    bus.stat_clr  = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rlog.delete();
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
  } vec_t;

  vec_t        vt[11];
  int unsigned acc;
  logic [31:0] exp_cx;
  logic [63:0] refv;
  logic [3:0]  er;
  bit          found;
  int          idx;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt = '{
      '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b1010, 4'b0010},
      '{4'b0010, 4'b0010}, '{4'b0000, 4'b0000}, '{4'b0101, 4'b0100}, '{4'b1001, 4'b1000},
      '{4'b1001, 4'b0001}, '{4'b0001, 4'b0001}, '{4'b1100, 4'b0100}
    };
    bus.req_x0 = '0; bus.req_y0 = '0; bus.req_z0 = '0;

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_drain_done", 64'(bus.drain_done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_core_x0", 64'(bus.core_x0), 64'd0);
    check("rst_core_y0", 64'(bus.core_y0), 64'd0);
    check("rst_core_z0", 64'(bus.core_z0), 64'd0);

    // single job from requester 2
    do_reset();
    bus.req_x0 = '0; bus.req_y0 = '0; bus.req_z0 = '0;
    bus.req_x0[2*DW +: DW] = 32'h0000_0400;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 64'(bus.req_ready), 64'(4'b0100));
    acc = cyc;
    tick();
    bus.req_valid = '0;
    repeat (25) tick();
    check("single_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() != 0) begin
      refv = cordic_ref(32'h0000_0400, 32'h0, 32'h0);
      check("single_latency", 64'(rlog[0].at - acc), 64'd18);
      check("single_id", 64'(rlog[0].id), 64'd2);
      check("single_x", 64'(rlog[0].x), 64'(refv[63:32]));
      check("single_y", 64'(rlog[0].y), 64'(refv[31:0]));
    end

    // arbitration table from the reset pointer
    do_reset();
    exp_cx = '0;
    for (int k = 0; k < 11; k++) begin
      set_data(k + 20);
      bus.req_valid = vt[k].valid;
      @(negedge clk);
      check($sformatf("tbl_ready%0d", k), 64'(bus.req_ready), 64'(vt[k].ready));
      idx = -1;
      for (int i = 0; i < NREQ; i++) if (vt[k].ready[i]) idx = i;
      if (idx >= 0) exp_cx = dx(k + 20, idx);
      tick();
      check($sformatf("tbl_core_x0_%0d", k), 64'(bus.core_x0), 64'(exp_cx));
    end
    bus.req_valid = '0;
    repeat (25) tick();

    // round-robin fairness, all requesters valid from reset
    do_reset();
    set_data(30);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      er = 4'b0001 << (k % 4);
      check($sformatf("rr_ready%0d", k), 64'(bus.req_ready), 64'(er));
      tick();
    end
    bus.req_valid = '0;
    repeat (25) tick();
    check("rr_rsp_count", 64'(rlog.size()), 64'd8);
    if (rlog.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("rr_rsp_id%0d", k), 64'(rlog[k].id), 64'(k % 4));
        check($sformatf("rr_rsp_at%0d", k), 64'(rlog[k].at - rlog[0].at), 64'(k));
      end
    end

    // drain: 5 jobs, drain_req raised with the fifth grant
    do_reset();
    set_data(40);
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) bus.drain_req = 1'b1;
      @(negedge clk);
      check($sformatf("drain_issue%0d", k), 64'(bus.req_ready), 64'(4'b0010));
      tick();
    end
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      check("drain_ready_low", 64'(bus.req_ready), 64'd0);
      if (!bus.busy) found = 1'b1;
    end
    check("drain_empty_timeout", 64'(found), 64'd1);
    check("drain_done_lag", 64'(bus.drain_done), 64'd0);
    @(negedge clk);
    check("drain_done_high", 64'(bus.drain_done), 64'd1);
    check("halted_ready_low", 64'(bus.req_ready), 64'd0);
    check("drain_rsp_count", 64'(rlog.size()), 64'd5);
    @(posedge clk); #1 bus.drain_req = 1'b0;
    @(negedge clk);
    check("resume_ready_wait", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("resume_ready", 64'(bus.req_ready), 64'(4'b0010));
    check("resume_done_low", 64'(bus.drain_done), 64'd0);
    tick();
    bus.req_valid = '0;
    repeat (25) tick();

    // reset mid-flight
    do_reset();
    set_data(60);
    bus.req_valid = 4'b0111;
    repeat (3) tick();
    bus.req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b0;
    rlog.delete();
    tick();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_rsp", 64'(rlog.size()), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_core_x0", 64'(bus.core_x0), 64'd0);

    // continuous traffic: issue and retire in the same cycle
    do_reset();
    set_data(80);
    bus.req_valid = 4'b1111;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check($sformatf("cont_inflight%0d", i), 64'(dut.r_inflight), 64'((i - 1 < 18) ? i - 1 : 18));
      if (i >= 2) check($sformatf("cont_busy%0d", i), 64'(bus.busy), 64'd1);
      tick();
    end
    bus.req_valid = '0;
    repeat (25) tick();

`ifdef CORDIC_RR_SCHED_STATS_EN
    do_reset();
    set_data(90);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("stat_reset", 64'(bus.stat_grants), 64'd0);
    repeat (100) tick();
    @(negedge clk);
    check("stat_count100", 64'(bus.stat_grants[15:0]), 64'd100);
    repeat (69900) tick();
    @(negedge clk);
    check("stat_saturate", 64'(bus.stat_grants[15:0]), 64'hFFFF);
    check("stat_others", 64'(bus.stat_grants[63:16]), 64'd0);
    tick();
    bus.stat_clr = 1'b1;
    @(negedge clk);
    check("stat_clr_grant", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.stat_clr = 1'b0;
    @(negedge clk);
    check("stat_cleared", 64'(bus.stat_grants[15:0]), 64'd0);
    tick();
    @(negedge clk);
    check("stat_restart", 64'(bus.stat_grants[15:0]), 64'd1);
    bus.req_valid = '0;
    repeat (25) tick();
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
